sc_stream_decoder: RTL and testbench

Stochastic-to-binary converter for the receiving end of an SNG stream. It accumulates the ones on N parallel stochastic bitstreams over a run of up to 2^TW beats, with optional early termination at power-of-two run lengths. It normalises each count to a TW-bit binary value and presents the results on a valid/ready output. It sits after the SC compute datapath and consumes the same-length streams the SNG side produces.

---
 rtl/sc_pkg.sv | 19 +
 rtl/sc_ones_acc.sv | 47 ++++
 rtl/sc_stream_decoder.sv | 110 +++++++++++
 tb/tb_sc_stream_decoder.sv | 183 ++++++++++++++++++
 4 files changed

// File: rtl/sc_pkg.sv
// Shared types and helpers for the stochastic stream decoder.
package sc_pkg;

  typedef enum logic [1:0] {IDLE, ACC, SCALE, DONE} dec_state_e;

  function automatic logic is_pow2(input logic [31:0] v);
    return (v != 32'd0) && ((v & (v - 32'd1)) == 32'd0);
  endfunction

  // Index of the highest set bit; exact log2 when v is a power of two.
  function automatic logic [4:0] log2_pow2(input logic [31:0] v);
    logic [4:0] r;
    r = '0;
    for (int i = 0; i < 32; i++)
      if (v[i]) r = 5'(i);
    return r;
  endfunction

endpackage

// File: rtl/sc_ones_acc.sv
// Per-channel ones counter plus shift/saturate normaliser to a TW-bit value.
module sc_ones_acc
  import sc_pkg::*;
#(
  parameter int TW = 8,
  parameter int KW = $clog2(TW + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clr_i,
  input  logic          inc_i,
  input  logic          bit_i,
  input  logic          ld_i,
  input  logic [KW-1:0] k_i,
  output logic [TW-1:0] z_o
);

  logic [TW:0]   cnt_q, cnt_d, scaled;
  logic [TW-1:0] z_q, z_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i)      cnt_d = '0;
    else if (inc_i) cnt_d = cnt_q + (TW+1)'(bit_i);
  end

  // count <= 2^k, so the shifted value tops out at exactly 2^TW (all ones seen).
  assign scaled = cnt_q << (KW'(TW) - k_i);

  always_comb begin
    z_d = z_q;
    if (ld_i) z_d = scaled[TW] ? {TW{1'b1}} : scaled[TW-1:0];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
      z_q   <= '0;
    end else begin
      cnt_q <= cnt_d;
      z_q   <= z_d;
    end
  end

  assign z_o = z_q;

endmodule

// File: rtl/sc_stream_decoder.sv
// Stochastic-to-binary decoder: FSM, beat counter, handshakes, N channel accumulators.
// Early termination (et input, pending flag) is built only when SC_DECODER_ET_EN is defined.
module sc_stream_decoder
  import sc_pkg::*;
#(
  parameter int TW = 8,
  parameter int N  = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [N-1:0]         bits,
  input  logic                 et,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [N-1:0][TW-1:0] Zs,
  output logic [TW:0]          len
);

  localparam int KW = $clog2(TW + 1);

  dec_state_e    state_q, state_d;
  logic [TW:0]   beat_q, beat_d, beat_inc, len_q, len_d;
  logic [KW-1:0] k;
  logic          run_start, acc_beat, term;

  assign run_start = (state_q == IDLE) && start;
  assign acc_beat  = (state_q == ACC) && in_valid;
  assign beat_inc  = beat_q + (TW+1)'(1);

`ifdef SC_DECODER_ET_EN
  logic pend_q, pend_d, inc_pow2;

  assign inc_pow2 = is_pow2(32'(beat_inc));
  assign term     = beat_inc[TW] || ((et || pend_q) && inc_pow2);

  always_comb begin
    pend_d = pend_q;
    if (run_start)                          pend_d = 1'b0;
    else if (acc_beat && et && !inc_pow2)   pend_d = 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) pend_q <= 1'b0;
    else     pend_q <= pend_d;
  end
`else
  logic unused_et;
  assign unused_et = et;
  assign term      = beat_inc[TW];
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start) state_d = ACC;
      ACC:     if (acc_beat && term) state_d = SCALE;
      SCALE:   state_d = DONE;
      DONE:    if (out_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    in_ready  = (state_q == ACC);
    out_valid = (state_q == DONE);
  end

  always_comb begin
    beat_d = beat_q;
    if (run_start)     beat_d = '0;
    else if (acc_beat) beat_d = beat_inc;
    len_d = (state_q == SCALE) ? beat_q : len_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      beat_q <= '0;
      len_q  <= '0;
    end else begin
      beat_q <= beat_d;
      len_q  <= len_d;
    end
  end

  // Run length is always a power of two by the time SCALE is reached.
  assign k   = KW'(log2_pow2(32'(beat_q)));
  assign len = len_q;

  for (genvar g = 0; g < N; g++) begin : g_ch
    sc_ones_acc #(.TW(TW), .KW(KW)) u_acc (
      .clk   (clk),
      .rst   (rst),
      .clr_i (run_start),
      .inc_i (acc_beat),
      .bit_i (bits[g]),
      .ld_i  (state_q == SCALE),
      .k_i   (k),
      .z_o   (Zs[g])
    );
  end

endmodule

// File: tb/tb_sc_stream_decoder.sv
// Randomised scoreboard bench for sc_stream_decoder (TW=4, N=2); model follows SC_DECODER_ET_EN.
module tb_sc_stream_decoder;
  localparam int TW = 4;
  localparam int N  = 2;
  localparam int FULL = 1 << TW;

  logic                 clk = 1'b0;
  logic                 rst, start, in_valid, in_ready, et, out_valid, out_ready;
  logic [N-1:0]         bits;
  logic [N-1:0][TW-1:0] Zs;
  logic [TW:0]          len;

  typedef struct packed {
    logic [N-1:0][TW-1:0] zs;
    logic [TW:0]          len;
  } exp_t;

  exp_t         q[$];
  int           total = 0;
  int           bad   = 0;
  logic [N-1:0] pat[FULL];

  sc_stream_decoder #(.TW(TW), .N(N)) dut (
    .clk(clk), .rst(rst), .start(start), .in_valid(in_valid), .in_ready(in_ready),
    .bits(bits), .et(et), .out_valid(out_valid), .out_ready(out_ready),
    .Zs(Zs), .len(len)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int got, input int want);
    total++;
    if (got != want) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, got, want, $time);
    end
  endtask

  // Monitor: pops on handshake, and checks outputs hold while stalled.
  logic hold = 1'b0;
  exp_t prev;
  always @(negedge clk) begin
    if (!rst && out_valid) begin
      if (hold) begin
        chk("hold_zs", int'(Zs), int'(prev.zs));
        chk("hold_len", int'(len), int'(prev.len));
      end
      if (out_ready) begin
        if (q.size() == 0) chk("unexpected_out", 1, 0);
        else begin
          exp_t e;
          e = q.pop_front();
          chk("zs0", int'(Zs[0]), int'(e.zs[0]));
          chk("zs1", int'(Zs[1]), int'(e.zs[1]));
          chk("len", int'(len), int'(e.len));
        end
      end
      hold <= !out_ready;
      prev <= '{zs: Zs, len: len};
    end else hold <= 1'b0;
  end

  // One run: start, feed beats (with gaps) until the model terminates, then drain with backpressure.
  task automatic run(input int et_at, input int abort_at, input int gap_pct, input int bp);
    int   L, guard;
    int   cnt[N];
    bit   pend, done, ispow;
    exp_t e;
    in_valid = 1'b1; bits = N'($urandom); start = 1'b0;
    @(negedge clk); chk("idle_in_ready", int'(in_ready), 0);
    @(posedge clk); #1 in_valid = 1'b0; start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    L = 0; pend = 0; done = 0; guard = 0;
    foreach (cnt[i]) cnt[i] = 0;
    while (!done && guard < 400) begin
      guard++;
      in_valid = ($urandom_range(99) >= gap_pct);
      bits     = pat[L];
      et       = (L + 1 == et_at);
      start    = 1'($urandom_range(1));
      @(negedge clk); chk("acc_in_ready", int'(in_ready), 1);
      @(posedge clk);
      if (in_valid) begin
        L++;
        for (int i = 0; i < N; i++) cnt[i] += int'(bits[i]);
        if (abort_at > 0 && L == abort_at) begin
          #1 rst = 1'b1; in_valid = 1'b0; start = 1'b0; et = 1'b0;
          #1;
          chk("abort_in_ready", int'(in_ready), 0);
          chk("abort_out_valid", int'(out_valid), 0);
          chk("abort_zs", int'(Zs), 0);
          chk("abort_len", int'(len), 0);
          @(negedge clk) rst = 1'b0;
          @(posedge clk); #1;
          return;
        end
        ispow = (L & (L - 1)) == 0;
`ifdef SC_DECODER_ET_EN
        if (L == FULL || ((et || pend) && ispow)) done = 1;
        else if (et) pend = 1;
`else
        done = (L == FULL);
`endif
      end
      #1;
    end
    in_valid = 1'b0; et = 1'b0; start = 1'b0;
    if (!done) chk("beat_timeout", 0, 1);
    for (int i = 0; i < N; i++) begin
      int z;
      z = cnt[i] * FULL / L;
      if (z > FULL - 1) z = FULL - 1;
      e.zs[i] = TW'(z);
    end
    e.len = (TW+1)'(L);
    q.push_back(e);
    @(negedge clk);
    chk("scale_in_ready", int'(in_ready), 0);
    chk("scale_out_valid", int'(out_valid), 0);
    @(negedge clk); chk("latency_out_valid", int'(out_valid), 1);
    for (int c = 0; c < bp; c++) begin
      @(posedge clk); #1 start = 1'($urandom_range(1)); in_valid = 1'b1; bits = N'($urandom);
      @(negedge clk);
      chk("bp_in_ready", int'(in_ready), 0);
      chk("bp_out_valid", int'(out_valid), 1);
    end
    @(posedge clk); #1 out_ready = 1'b1; start = 1'($urandom_range(1)); in_valid = 1'b0;
    @(posedge clk); #1 out_ready = 1'b0; start = 1'b0;
    @(negedge clk);
    chk("post_out_valid", int'(out_valid), 0);
    chk("post_in_ready", int'(in_ready), 0);
    @(posedge clk); #1;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    rst = 1'b1; start = 1'b0; in_valid = 1'b0; bits = '0; et = 1'b0; out_ready = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_in_ready", int'(in_ready), 0);
    chk("rst_out_valid", int'(out_valid), 0);
    chk("rst_zs", int'(Zs), 0);
    chk("rst_len", int'(len), 0);
    rst = 1'b0;
    @(posedge clk); #1;

    // ch0 10 ones, ch1 zero, full run
    for (int i = 0; i < FULL; i++) pat[i] = {1'b0, 1'(i < 10)};
    run(0, 0, 0, 0);
    // ch0 all ones (saturates), ch1 alternating
    for (int i = 0; i < FULL; i++) pat[i] = {1'(i % 2), 1'b1};
    run(0, 0, 20, 1);
    // et on beat 4, ch0 3 ones
    for (int i = 0; i < FULL; i++) pat[i] = {1'b1, 1'(i < 3)};
    run(4, 0, 0, 3);
    // et on beat 5, ch0 5 ones in first 8 beats
    for (int i = 0; i < FULL; i++) pat[i] = {1'b0, 1'(i < 5)};
    run(5, 0, 0, 0);
    // run of length 1
    for (int i = 0; i < FULL; i++) pat[i] = 2'b01;
    run(1, 0, 0, 2);
    // reset mid-run at beat 7, then a clean full run
    for (int i = 0; i < FULL; i++) pat[i] = 2'b11;
    run(0, 7, 0, 0);
    for (int i = 0; i < FULL; i++) pat[i] = {1'b1, 1'(i < 6)};
    run(0, 0, 0, 0);

    for (int r = 0; r < 25; r++) begin
      for (int i = 0; i < FULL; i++) pat[i] = N'($urandom);
      run($urandom_range(20), 0, $urandom_range(40), $urandom_range(3));
    end

    repeat (3) @(posedge clk);
    chk("queue_empty", q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
